// File: rtl/fir_mc_pipe.sv
// fir_mc_pipe: multi-channel direct-form FIR compute core.
//   Time-interleaved channels share one multiplier array. Each channel keeps
//   its own sample history. Coefficients are double-buffered: the controller
//   writes a shadow bank and commits it, together with a tap count, to the
//   active bank. Stage 1 registers the tap products. Stage 2 sums them, then
//   rounds (half up), saturates and presents the result on the output bus.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_data       sample input; channel comes from an internal pointer
//   out_valid/out_ready/out_data    filtered output
//   out_ch, out_sat                 channel of out_data, saturation flag
//   tap_wr_en/tap_wr_addr/tap_wr_data  shadow coefficient write
//   tap_num, tap_commit             active tap count; shadow -> active copy
//   flush                           clear histories, pointer and pipeline
module fir_mc_pipe #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 8,
  parameter int NUM_CH   = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15,
  localparam int TAP_AW  = $clog2(NUM_TAPS),
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_sat,
  input  logic                     tap_wr_en,
  input  logic [TAP_AW-1:0]        tap_wr_addr,
  input  logic signed [COEF_W-1:0] tap_wr_data,
  input  logic [TAP_AW:0]          tap_num,
  input  logic                     tap_commit,
  input  logic                     flush
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + TAP_AW + 1;
  // One extra bit so the rounding offset can never wrap the accumulator.
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'((RND_W'(1) << SHIFT) >> 1);
  localparam logic signed [RND_W-1:0] OUT_MAX  = RND_W'({(OUT_W-1){1'b1}});
  localparam logic signed [RND_W-1:0] OUT_MIN  = ~OUT_MAX;

  function automatic logic signed [RND_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [RND_W-1:0] t;
    t = RND_W'(a) + RND_HALF;
    return t >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [RND_W-1:0] r);
    if (r > OUT_MAX)      return {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (r < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
    else                  return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic signed [DATA_W-1:0] hist [NUM_CH][NUM_TAPS-1];
  logic signed [COEF_W-1:0] coef_act [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_shd [NUM_TAPS];
  logic signed [COEF_W-1:0] shd_next [NUM_TAPS];
  logic [TAP_AW:0]          tap_cnt;
  logic [TAP_AW:0]          tap_num_cl;
  logic [CH_W-1:0]          ch_ptr;

  logic en, accept;
  logic signed [DATA_W-1:0] x    [NUM_TAPS];
  logic signed [PROD_W-1:0] prod [NUM_TAPS];

  logic signed [PROD_W-1:0] prod_p1 [NUM_TAPS];
  logic [CH_W-1:0]          ch_p1;
  logic                     vld_p1;

  logic signed [ACC_W-1:0]  acc_sum;
  logic [OUT_W:0]           sat_res;

  // Flow control: the whole pipe advances unless the output is stalled.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en & ~flush;
  assign accept   = in_valid & in_ready;

  // A write in the commit cycle must already be visible to the copy.
  always_comb begin
    shd_next = coef_shd;
    if (tap_wr_en && (int'(tap_wr_addr) < NUM_TAPS)) shd_next[tap_wr_addr] = tap_wr_data;
  end

  always_comb begin
    if (tap_num == '0)                 tap_num_cl = (TAP_AW+1)'(1);
    else if (int'(tap_num) > NUM_TAPS) tap_num_cl = (TAP_AW+1)'(NUM_TAPS);
    else                               tap_num_cl = tap_num;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_shd[i] <= '0;
        coef_act[i] <= '0;
      end
      tap_cnt <= (TAP_AW+1)'(NUM_TAPS);
    end else begin
      coef_shd <= shd_next;
      if (tap_commit) begin
        coef_act <= shd_next;
        tap_cnt  <= tap_num_cl;
      end
    end
  end

  always_comb begin
    x[0] = in_data;
    for (int i = 1; i < NUM_TAPS; i++) x[i] = hist[ch_ptr][i-1];
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod[i] = ((TAP_AW+1)'(i) < tap_cnt) ? PROD_W'(x[i]) * PROD_W'(coef_act[i]) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < NUM_TAPS-1; j++) hist[c][j] <= '0;
      ch_ptr <= '0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < NUM_TAPS-1; j++) hist[c][j] <= '0;
      ch_ptr <= '0;
    end else if (accept) begin
      for (int j = NUM_TAPS-2; j > 0; j--) hist[ch_ptr][j] <= hist[ch_ptr][j-1];
      hist[ch_ptr][0] <= in_data;
      ch_ptr <= (int'(ch_ptr) == NUM_CH-1) ? '0 : ch_ptr + CH_W'(1);
    end
  end

  // ---- stage 1 boundary: tap products ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) prod_p1[i] <= '0;
      ch_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= accept;
      if (accept) begin
        prod_p1 <= prod;
        ch_p1   <= ch_ptr;
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) acc_sum = acc_sum + ACC_W'(prod_p1[i]);
  end

  assign sat_res = saturate(round_shift(acc_sum));

  // ---- stage 2 boundary: rounded, saturated output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= sat_res[OUT_W-1:0];
        out_sat  <= sat_res[OUT_W];
        out_ch   <= ch_p1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mc_pipe.sv
// Testbench for fir_mc_pipe (default build: 2 channels, 8 taps, SHIFT 15).
module tb_fir_mc_pipe;
  localparam int NUM_TAPS = 8;
  localparam int NUM_CH   = 2;
  localparam int SHIFT    = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [15:0] in_data, out_data, tap_wr_data;
  logic [0:0] out_ch;
  logic tap_wr_en, tap_commit, flush;
  logic [2:0] tap_wr_addr;
  logic [3:0] tap_num;

  always #5 clk = ~clk;

  fir_mc_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sat(out_sat),
    .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr), .tap_wr_data(tap_wr_data),
    .tap_num(tap_num), .tap_commit(tap_commit), .flush(flush)
  );

  typedef struct { int data; int ch; bit sat; int cyc; } smp_t;
  smp_t exp_q[$];
  smp_t got_q[$];

  int  hist_m [NUM_CH][NUM_TAPS];   // index 0 = newest past sample
  int  act_m  [NUM_TAPS];
  int  shd_m  [NUM_TAPS];
  int  cnt_m, ptr_m;
  int  n_cmp = 0, n_err = 0, cyc = 0;
  int  rdy_lo_pct = 0;
  bit  last_acc, lat_chk;
  bit  prev_stall;
  int  prev_data, prev_ch;
  bit  prev_sat;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < NUM_TAPS; i++) hist_m[c][i] = 0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      act_m[i] = 0;
      shd_m[i] = 0;
    end
    cnt_m = NUM_TAPS;
    ptr_m = 0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  // y = sum_{i<count} x[n-i]*h[i], round half up after >>SHIFT, clip to 16 bits.
  task automatic model_accept(input int d);
    longint acc, r;
    int xs [NUM_TAPS];
    smp_t e;
    xs[0] = d;
    for (int i = 1; i < NUM_TAPS; i++) xs[i] = hist_m[ptr_m][i-1];
    acc = 0;
    for (int i = 0; i < cnt_m; i++) acc += longint'(xs[i]) * longint'(act_m[i]);
    r = (acc + ((SHIFT > 0) ? (64'sd1 <<< (SHIFT-1)) : 64'sd0)) >>> SHIFT;
    e.sat = 1'b0;
    if (r > 32767)       begin r = 32767;  e.sat = 1'b1; end
    else if (r < -32768) begin r = -32768; e.sat = 1'b1; end
    e.data = int'(r);
    e.ch   = ptr_m;
    e.cyc  = cyc;
    exp_q.push_back(e);
    for (int i = NUM_TAPS-1; i > 0; i--) hist_m[ptr_m][i] = hist_m[ptr_m][i-1];
    hist_m[ptr_m][0] = d;
    ptr_m = (ptr_m + 1) % NUM_CH;
  endtask

  // One clock: observe at negedge, update model, advance past posedge.
  task automatic tick();
    smp_t e, g;
    int n;
    @(negedge clk);
    if (!flush) check("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", int'(out_data), prev_data);
      check("hold_ch", out_ch, prev_ch);
      check("hold_sat", out_sat, prev_sat);
    end
    prev_stall = out_valid && !out_ready && !flush;
    prev_data  = int'(out_data);
    prev_ch    = int'(out_ch);
    prev_sat   = out_sat;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL extra_output: observed data %0d expected no output", out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", int'(out_data), e.data);
        check("out_ch", out_ch, e.ch);
        check("out_sat", out_sat, e.sat);
        if (lat_chk) check("latency", cyc - e.cyc, 2);
      end
      g.data = int'(out_data); g.ch = int'(out_ch); g.sat = out_sat; g.cyc = cyc;
      got_q.push_back(g);
    end
    last_acc = in_valid && in_ready;
    if (flush) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < NUM_TAPS; i++) hist_m[c][i] = 0;
      ptr_m = 0;
      exp_q.delete();
    end else if (last_acc) begin
      model_accept(int'(in_data));
    end
    if (tap_wr_en && int'(tap_wr_addr) < NUM_TAPS) shd_m[tap_wr_addr] = int'(tap_wr_data);
    if (tap_commit) begin
      act_m = shd_m;
      n = int'(tap_num);
      if (n < 1) n = 1;
      if (n > NUM_TAPS) n = NUM_TAPS;
      cnt_m = n;
    end
    @(posedge clk);
    #1;
    cyc++;
    out_ready = ($urandom_range(0, 99) >= rdy_lo_pct);
  endtask

  task automatic push(input logic signed [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    last_acc = 1'b0;
    for (int k = 0; k < 200 && !last_acc; k++) tick();
    n_cmp++;
    assert (last_acc) else begin
      n_err++;
      $error("FAIL push_timeout: observed no accept expected accept of %0d", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 500 && exp_q.size() > 0; k++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic write_tap(input int a, input logic signed [15:0] d);
    tap_wr_en   = 1'b1;
    tap_wr_addr = 3'(a);
    tap_wr_data = d;
    tick();
    tap_wr_en = 1'b0;
  endtask

  task automatic load_all(input logic signed [15:0] d, input int num);
    for (int i = 0; i < NUM_TAPS; i++) write_tap(i, d);
    tap_num    = 4'(num);
    tap_commit = 1'b1;
    tick();
    tap_commit = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_ch"}, out_ch, 0);
    check({tag, "_out_sat"}, out_sat, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tap_wr_en = 1'b0; tap_wr_addr = '0; tap_wr_data = '0;
    tap_num = 4'd8; tap_commit = 1'b0; flush = 1'b0;
    lat_chk = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse through 8 taps of 0.5: 0x7FFF*0x4000>>15 = 16383.5 -> 16384.
    lat_chk = 1'b1;
    load_all(16'sh4000, 8);
    do_flush();
    got_q.delete();
    push(16'sh7FFF);
    for (int k = 0; k < 17; k++) push(16'sh0000);
    drain();
    lat_chk = 1'b0;
    check("imp_count", got_q.size(), 18);
    if (got_q.size() == 18) begin
      for (int k = 0; k < 8; k++) check("imp_ch0", got_q[2*k].data, 16384);
      check("imp_tail", got_q[16].data, 0);
      for (int k = 0; k < 9; k++) check("imp_ch1", got_q[2*k+1].data, 0);
    end

    // Interleave: ch0 impulse of 100 (-> 50 per tap), ch1 all zeros.
    do_flush();
    got_q.delete();
    push(16'sd100); push(16'sd0);
    for (int k = 0; k < 7; k++) begin push(16'sd0); push(16'sd0); end
    drain();
    check("ilv_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      for (int k = 0; k < 16; k++) check("ilv_ch", got_q[k].ch, k % 2);
      for (int k = 0; k < 8; k++) check("ilv_ch0", got_q[2*k].data, 50);
      for (int k = 0; k < 8; k++) check("ilv_ch1", got_q[2*k+1].data, 0);
    end

    // Saturation, positive and negative.
    load_all(16'sh7FFF, 8);
    do_flush();
    got_q.delete();
    for (int k = 0; k < 8; k++) push(16'sh7FFF);
    drain();
    check("satp_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check("satp_data", got_q[7].data, 32767);
      check("satp_flag", got_q[7].sat, 1);
      check("satp_first", got_q[0].sat, 0);
    end
    do_flush();
    got_q.delete();
    for (int k = 0; k < 8; k++) push(-16'sd32768);
    drain();
    check("satn_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check("satn_data", got_q[7].data, -32768);
      check("satn_flag", got_q[7].sat, 1);
    end

    // Commit coinciding with an accept: that sample sees 8 old taps (16384),
    // the next one 3 new taps of 0x7FFF (3*0x1000*0x7FFF>>15 -> 12288).
    load_all(16'sh4000, 8);
    for (int i = 0; i < NUM_TAPS; i++) write_tap(i, 16'sh7FFF);
    do_flush();
    got_q.delete();
    for (int k = 0; k < 16; k++) push(16'sh1000);
    tap_num = 4'd3; tap_commit = 1'b1;
    push(16'sh1000);
    tap_commit = 1'b0;
    push(16'sh1000);
    drain();
    check("cmt_count", got_q.size(), 18);
    if (got_q.size() == 18) begin
      check("cmt_before", got_q[15].data, 16384);
      check("cmt_same", got_q[16].data, 16384);
      check("cmt_after", got_q[17].data, 12288);
    end

    // Tap count clamp: tap_num=0 becomes 1 tap.
    load_all(16'sh4000, 0);
    do_flush();
    got_q.delete();
    push(16'sh7FFF); push(16'sh0000); push(16'sh0000); push(16'sh0000);
    drain();
    check("clamp_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("clamp_first", got_q[0].data, 16384);
      check("clamp_second", got_q[2].data, 0);
    end

    // Random stream with 30% backpressure and occasional coefficient updates.
    for (int i = 0; i < NUM_TAPS; i++) write_tap(i, 16'($urandom));
    tap_num = 4'd8; tap_commit = 1'b1; tick(); tap_commit = 1'b0;
    rdy_lo_pct = 30;
    for (int k = 0; k < 1000; k++) begin
      push(16'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        write_tap($urandom_range(0, 7), 16'($urandom));
        tap_num = 4'($urandom_range(0, 15));
        tap_commit = 1'b1;
        push(16'($urandom));
        tap_commit = 1'b0;
      end
    end
    drain();

    // Flush while the output is stalled.
    rdy_lo_pct = 0;
    load_all(16'sh4000, 8);
    rdy_lo_pct = 100;
    out_ready = 1'b0;
    push(16'sd1000);
    push(16'sd2000);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    do_flush();
    check("flush_valid", out_valid, 0);
    rdy_lo_pct = 0;
    out_ready = 1'b1;
    tick();
    check("flush_s1_gone", out_valid, 0);
    got_q.delete();
    push(16'sh7FFF);
    for (int k = 0; k < 17; k++) push(16'sh0000);
    drain();
    check("flush_count", got_q.size(), 18);
    if (got_q.size() == 18) begin
      check("flush_ptr", got_q[0].ch, 0);
      check("flush_imp0", got_q[0].data, 16384);
      check("flush_ch1_clean", got_q[1].data, 0);
      check("flush_imp7", got_q[14].data, 16384);
      check("flush_tail", got_q[16].data, 0);
    end

    // Reset asserted in the middle of a backpressured stream.
    rdy_lo_pct = 30;
    for (int k = 0; k < 20; k++) push(16'($urandom));
    in_valid = 1'b1;
    in_data  = 16'sh1234;
    #2;
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    got_q.delete();
    in_valid = 1'b0;
    rdy_lo_pct = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Coefficients were cleared by reset: output must be 0.
    push(16'sh7FFF);
    drain();
    check("rst_coef_count", got_q.size(), 1);
    if (got_q.size() == 1) check("rst_coef_zero", got_q[0].data, 0);
    load_all(16'sh4000, 8);
    do_flush();
    got_q.delete();
    push(16'sh7FFF); push(16'sh0000);
    drain();
    check("rst_imp_count", got_q.size(), 2);
    if (got_q.size() == 2) check("rst_imp", got_q[0].data, 16384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
